// File: rtl/apb_reg_slave.sv
// APB completer backing a word-addressed register file; completes after WAIT_CYCLES+1 ACCESS cycles.
// Responses are combinational from state and bus; out-of-window, misaligned or SETUP-less accesses error.
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hA000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);

  localparam int          IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [31:0]       r_regs [NUM_REGS];

  logic              w_access;
  logic              w_proto_err;
  logic              w_complete;
  logic [31:0]       w_off;
  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr_en;

  assign w_access    = psel_i & penable_i;
  assign w_proto_err = (r_state == ST_IDLE) & w_access;
  assign w_complete  = (r_state == ST_WAIT) & w_access & (r_cnt == 4'd0);

  // Below-base addresses wrap to a huge offset and fall out of the window.
  assign w_off   = paddr_i - BASE_ADDR;
  assign w_hit   = (paddr_i[1:0] == 2'b00) && (w_off < WIN_BYTES);
  assign w_idx   = w_off[IDX_W+1:2];
  assign w_wr_en = w_complete & w_hit & pwrite_i;

  always_comb begin
    pready_o  = w_proto_err | w_complete;
    pslverr_o = w_proto_err | (w_complete & ~w_hit);
    prdata_o  = 32'd0;
    if (w_complete && w_hit && !pwrite_i) begin
      prdata_o = r_regs[w_idx];
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (psel_i && !penable_i) begin
            r_state <= ST_WAIT;
            r_cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!psel_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else if (penable_i) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
      if (w_wr_en) begin
        r_regs[w_idx] <= pwdata_i;
      end
    end
  end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB completer that consumes the transfers issued by the team's APB adder master and backs them with a small word-addressed register file. Decodes a configurable base window, inserts a programmable number of wait states, and flags out-of-window, misaligned or protocol-violating accesses with `pslverr_o`. Together with the adder master it forms a closed read-increment-write loop at address 0xA000.

## Interface
- `BASE_ADDR`, 32'hA000: byte address of register 0.
- `NUM_REGS`, 16: number of 32-bit RW registers; power of two, 2..256.
- `WAIT_CYCLES`, 1: extra ACCESS cycles before `pready_o`; 0..15.
- `pclk` in 1: clock; all state updates on the rising edge.
- `preset_n` in 1: reset, synchronous, active-low.
- `psel_i` in 1: slave select.
- `penable_i` in 1: access phase.
- `paddr_i` in 32: byte address.
- `pwrite_i` in 1: 1 = write, 0 = read.
- `pwdata_i` in 32: write data.
- `prdata_o` out 32: read data.
- `pready_o` out 1: transfer completes this cycle.
- `pslverr_o` out 1: error response, qualified by `pready_o`.

## Operation
- State machine with registered state `ST_IDLE` and `ST_WAIT`, plus a 4-bit wait counter `cnt`.
- `ST_IDLE`:
  - On `psel_i & ~penable_i` (SETUP): go to `ST_WAIT` and load `cnt = WAIT_CYCLES`.
  - On `psel_i & penable_i` (ACCESS without SETUP): protocol error. Drive `pready_o=1` and `pslverr_o=1` combinationally this cycle. No write occurs. Stay in `ST_IDLE`.
- `ST_WAIT`:
  - If `psel_i & penable_i & cnt!=0`: decrement `cnt`.
  - If `psel_i & penable_i & cnt==0`: complete the transfer and return to `ST_IDLE`.
  - If `psel_i` deasserts: abort to `ST_IDLE` with no side effects.
- Address, `pwrite_i` and `pwdata_i` are sampled only in the completion cycle. The master drives `paddr` to 0 in SETUP, so the slave does not decode addresses in SETUP.
- Decode, with `off = paddr_i - BASE_ADDR` (32-bit wrap):
  - Hit when `paddr_i[1:0]==0` and `off < NUM_REGS*4`.
  - Index is `off[log2(NUM_REGS)+1:2]`.
- Hit write: `reg[idx] <= pwdata_i` on the completion edge; `pslverr_o=0`.
- Hit read: `prdata_o = reg[idx]` during the completion cycle; `pslverr_o=0`.
- Miss (out-of-window or misaligned): `pslverr_o=1`, no register changes, `prdata_o=0`.
- `prdata_o` is 0 whenever `pready_o=0` or `pwrite_i=1`. `pslverr_o` is 0 whenever `pready_o=0`.
- Write data is stored verbatim: no masking, no arithmetic.

## Timing
- Reset (`preset_n=0` at a rising edge):
  - State becomes `ST_IDLE`, `cnt=0`, all registers become 0.
  - Outputs: `pready_o=0`, `pslverr_o=0`, `prdata_o=0`.
- Reset has priority over a completing write in the same edge; that write is lost.
- Reset asserted mid-transfer: the next cycle is `ST_IDLE`. A master still holding ACCESS then receives the protocol-error response.
- Outputs are combinational from registered state and current inputs. `pready_o` asserts in the same cycle as `penable_i` when `WAIT_CYCLES=0`.
- Transfer length is SETUP + (`WAIT_CYCLES`+1) ACCESS cycles, i.e. `WAIT_CYCLES`+2 cycles.
- Back-to-back transfers: a SETUP in the cycle after completion is accepted with no idle gap.
- A read in the cycle after a write to the same register returns the new value.
- Address wrap: `paddr_i < BASE_ADDR` underflows to a large `off` and is a miss.

## Test plan
- Reset, then read at 0xA000 with `WAIT_CYCLES=1`:
  - `pready_o` high on the 2nd ACCESS cycle.
  - `prdata_o=0`, `pslverr_o=0`.
- Write 0xDEADBEEF to 0xA03C, then read 0xA03C:
  - Read returns 0xDEADBEEF.
  - Write to 0xA040 gives `pslverr_o=1` and reg15 is unchanged.
  - Read at 0xA002 gives `pslverr_o=1` and `prdata_o=0`.
- Connect to the adder master and issue add 01/11 three times:
  - reg0 reads 0, 1, 2 in turn.
  - Final write value is 3.
- `WAIT_CYCLES=0` and `WAIT_CYCLES=15`:
  - ACCESS lasts exactly 1 and 16 cycles respectively.
  - `pready_o` is never high outside ACCESS.
- Protocol error and abort:
  - `psel_i=penable_i=1` with no SETUP: `pready_o=pslverr_o=1` the same cycle, no write.
  - `psel_i` dropped during wait states: back to IDLE, no write.
- Reset mid-write in the completion cycle (reg3=0x55 beforehand): reg3 reads 0 afterwards and all outputs are 0 the next cycle.
